// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a single shared combinational ALU.
// A request is accepted in IDLE and its operands are registered. The ALU
// result is captured in EXEC. The response is held in RESP until the consumer
// takes it. That gives one operation every three cycles at most.
// Optional feature: define ALU_ARB_ROUND_ROBIN_EN so that simultaneous
// requests alternate between the two requesters. When the macro is undefined,
// requester 0 always wins a tie.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req0_ctrl,
  input  logic [3:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_a1,
  output logic [WIDTH-1:0] alu_a2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  input  logic             rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  // Accepted operation (stage 0) and captured response (stage 1)
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [3:0]       ctrl_p0;
  logic             id_p0;
  logic [WIDTH-1:0] result_p1;
  logic             zero_p1;
  logic             err_p1;
  logic             vld_p1;

  logic grant0;
  logic grant1;
  logic open_window;
  logic accept;
  logic pick1;

  // Opcodes 1..7 are the ones the shared ALU implements.
  function automatic logic op_legal(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd7);
  endfunction

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Index of the requester accepted most recently. It resets to 1 so that
  // requester 0 wins the first tie.
  logic last_grant;

  // Round-robin winner: on a tie, pick the requester that was not granted last
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (last_grant) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end
`else
  // Fixed-priority winner: requester 0 always beats requester 1
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid && !req0_valid;
  end
`endif

  // Grants are only offered in IDLE, and never in a cycle where rst is high
  assign open_window = (state == IDLE) && !rst;
  assign req0_ready  = open_window && grant0;
  assign req1_ready  = open_window && grant1;
  assign accept      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign pick1       = req1_ready;

  // The ALU only ever sees registered operands, so it stays stable through EXEC
  assign alu_a1     = a_p0;
  assign alu_a2     = b_p0;
  assign alu_ctrl   = ctrl_p0;

  assign rsp_valid  = vld_p1;
  assign rsp_id     = id_p0;
  assign rsp_result = result_p1;
  assign rsp_zero   = zero_p1;
  assign rsp_err    = err_p1;

  // Sequencer: accept in IDLE, capture in EXEC, hold the response in RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vld_p1    <= 1'b0;
      id_p0     <= 1'b0;
      a_p0      <= '0;
      b_p0      <= '0;
      ctrl_p0   <= 4'b0000;
      result_p1 <= '0;
      zero_p1   <= 1'b0;
      err_p1    <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        // Stage 0: register the winner's operation
        IDLE: begin
          if (accept) begin
            a_p0    <= pick1 ? req1_a : req0_a;
            b_p0    <= pick1 ? req1_b : req0_b;
            ctrl_p0 <= pick1 ? req1_ctrl : req0_ctrl;
            id_p0   <= pick1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_grant <= pick1;
`endif
            state   <= EXEC;
          end
        end
        // Stage 1: capture the ALU output, or force the error response
        EXEC: begin
          if (op_legal(ctrl_p0)) begin
            result_p1 <= alu_result;
            zero_p1   <= alu_zero;
            err_p1    <= 1'b0;
          end else begin
            result_p1 <= '0;
            zero_p1   <= 1'b1;
            err_p1    <= 1'b1;
          end
          vld_p1 <= 1'b1;
          state  <= RESP;
        end
        // Response handshake: hold everything stable until the consumer is ready
        RESP: begin
          if (rsp_ready) begin
            vld_p1 <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          vld_p1 <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
